karatsuba_mul_arbiter: RTL

KARATSUBA_MUL_ARBITER -- requirements
Module: karatsuba_mul_arbiter

---
 rtl/karatsuba_pkg.sv | 18 +
 rtl/karatsuba_mul.sv | 41 ++++
 rtl/karatsuba_mul_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/karatsuba_pkg.sv
// rtl/karatsuba_pkg.sv - shared FSM encoding and parameter limits for the Karatsuba multiplier arbiter
package karatsuba_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int MUL_CYCLES_MIN = 1;
  localparam int MUL_CYCLES_MAX = 15;
  localparam int CNT_W          = 4;

  function automatic bit mul_cycles_ok(input int m);
    return (m >= MUL_CYCLES_MIN) && (m <= MUL_CYCLES_MAX);
  endfunction

endpackage

// File: rtl/karatsuba_mul.sv
// rtl/karatsuba_mul.sv - combinational unsigned multiplier, one-level Karatsuba split
module karatsuba_mul #(
  parameter int N_BITS = 15
) (
  input  logic [N_BITS-1:0]   a,
  input  logic [N_BITS-1:0]   b,
  output logic [2*N_BITS-1:0] p
);

  localparam int W = 2 * N_BITS;

  generate
    if (N_BITS < 4) begin : g_direct
      assign p = W'(a) * W'(b);
    end else begin : g_kara
      localparam int L = (N_BITS + 1) / 2;
      localparam int H = N_BITS - L;

      logic [L-1:0] al, bl;
      logic [H-1:0] ah, bh;
      logic [L:0]   sa, sb;
      logic [W-1:0] z0, z2, zm, mid;

      // Middle term is formed modulo 2^W; the final sum is exact because the product fits in W bits.
      always_comb begin
        al  = a[L-1:0];
        bl  = b[L-1:0];
        ah  = a[N_BITS-1:L];
        bh  = b[N_BITS-1:L];
        sa  = (L+1)'(al) + (L+1)'(ah);
        sb  = (L+1)'(bl) + (L+1)'(bh);
        z0  = W'(al) * W'(bl);
        z2  = W'(ah) * W'(bh);
        zm  = W'(sa) * W'(sb);
        mid = zm - z0 - z2;
        p   = (z2 << (2 * L)) + (mid << L) + z0;
      end
    end
  endgenerate

endmodule

// File: rtl/karatsuba_mul_arbiter.sv
// rtl/karatsuba_mul_arbiter.sv - round-robin arbiter sharing one multi-cycle multiplier between two requesters
module karatsuba_mul_arbiter
  import karatsuba_pkg::*;
#(
  parameter int N_BITS     = 15,
  parameter int MUL_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [N_BITS-1:0]   req0_a,
  input  logic [N_BITS-1:0]   req0_b,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [N_BITS-1:0]   req1_a,
  input  logic [N_BITS-1:0]   req1_b,
  output logic                resp0_valid,
  input  logic                resp0_ready,
  output logic                resp1_valid,
  input  logic                resp1_ready,
  output logic [2*N_BITS-1:0] resp_c,
  output logic                busy
);

  localparam int W = 2 * N_BITS;

  generate
    if (!mul_cycles_ok(MUL_CYCLES) || N_BITS < 1) begin : g_bad_param
      $error("karatsuba_mul_arbiter: MUL_CYCLES must be 1..15 and N_BITS >= 1");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic [N_BITS-1:0]  a_q, a_d, b_q, b_d;
  logic [W-1:0]       c_q, c_d;
  logic               busy_q, busy_d;
  logic               resp0_valid_q, resp0_valid_d;
  logic               resp1_valid_q, resp1_valid_d;
  logic               grant, rdy0, rdy1;
  logic [W-1:0]       mul_p;

  karatsuba_mul #(.N_BITS(N_BITS)) u_mul (
    .a (a_q),
    .b (b_q),
    .p (mul_p)
  );

  always_comb begin
    // grant is the requester index; a lone valid wins, a tie goes to whoever was not served last
    grant = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    rdy0  = (state_q == ST_IDLE) && !rst && req0_valid && !grant;
    rdy1  = (state_q == ST_IDLE) && !rst && req1_valid && grant;

    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;

    case (state_q)
      ST_IDLE: begin
        if (rdy0 || rdy1) begin
          a_d     = grant ? req1_a : req0_a;
          b_d     = grant ? req1_b : req0_b;
          owner_d = grant;
          last_d  = grant;
          cnt_d   = CNT_W'(MUL_CYCLES - 1);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          c_d     = mul_p;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (owner_q ? resp1_ready : resp0_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d        = (state_d != ST_IDLE);
    resp0_valid_d = (state_d == ST_DONE) && !owner_d;
    resp1_valid_d = (state_d == ST_DONE) && owner_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      owner_q       <= 1'b0;
      last_q        <= 1'b1;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      busy_q        <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      a_q           <= a_d;
      b_q           <= b_d;
      c_q           <= c_d;
      busy_q        <= busy_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
    end
  end

  assign req0_ready  = rdy0;
  assign req1_ready  = rdy1;
  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp_c      = c_q;
  assign busy        = busy_q;

endmodule
